// File: rtl/cache_defs.sv
// Shared dcache subsystem definitions: line/address geometry, memory latencies
// and the memory responder state encoding.
package cache_defs;

    localparam int DCACHE_ADDR_WIDTH  = 32;
    localparam int DCACHE_LINE_WIDTH  = 128;
    localparam int DCACHE_OFFSET_BITS = 4;
    localparam int MEM_RD_LATENCY     = 4;
    localparam int MEM_WR_LATENCY     = 4;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_ACK  = 2'd2
    } type_mem_resp_state_e;

endpackage

// File: rtl/mem_line_ram.sv
// Line-wide backing storage: synchronous write, synchronous enabled read.
// The read register holds the last line read, so it doubles as the
// responder's read-data output and is the only part of the RAM that resets.
module mem_line_ram #(
    parameter int LINES = 1024,
    parameter int WIDTH = 128,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [LINES];

    // Commit a whole line; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Register the addressed line only when a read is performed, holding it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for dcache line refills and writebacks.
// A request is captured when accepted in IDLE; the access is performed on the
// edge where the latency counter runs out, and ACK follows for one cycle.
// With a latency of N the ack is visible in the Nth cycle after the accept edge.
module dcache_mem_responder
    import cache_defs::*;
#(
    parameter int ADDR_WIDTH  = DCACHE_ADDR_WIDTH,
    parameter int LINE_WIDTH  = DCACHE_LINE_WIDTH,
    parameter int OFFSET_BITS = DCACHE_OFFSET_BITS,
    parameter int MEM_LINES   = 1024,
    parameter int RD_LATENCY  = MEM_RD_LATENCY,
    parameter int WR_LATENCY  = MEM_WR_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dcache2mem_req_i,
    input  logic                  dcache2mem_wr_i,
    input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
    output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
    output logic                  mem2dcache_ack_o,
    output logic                  mem_busy_o
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);

    type_mem_resp_state_e state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic [3:0]            load_val;

    logic                  cap_wr;
    logic [IDX_W-1:0]      cap_idx;
    logic [LINE_WIDTH-1:0] cap_data;

    logic                  accept;
    logic                  access;
    logic                  direct;

    logic [IDX_W-1:0]      req_idx;
    logic                  acc_wr;
    logic [IDX_W-1:0]      acc_idx;
    logic [LINE_WIDTH-1:0] acc_data;
    logic                  ram_we;
    logic                  ram_re;
    logic                  unused_addr;

    assign req_idx     = dcache2mem_addr_i[OFFSET_BITS +: IDX_W];
    assign load_val    = dcache2mem_wr_i ? WR_LOAD : RD_LOAD;
    assign unused_addr = ^dcache2mem_addr_i;

    // A one-cycle latency accesses straight from the request inputs at the accept edge.
    assign acc_wr   = direct ? dcache2mem_wr_i   : cap_wr;
    assign acc_idx  = direct ? req_idx           : cap_idx;
    assign acc_data = direct ? dcache2mem_data_i : cap_data;

    // Reset blocks any commit or read landing on the same edge.
    assign ram_we = access & acc_wr & ~rst;
    assign ram_re = access & ~acc_wr & ~rst;

    assign mem2dcache_ack_o = (state == MEM_ACK);
    assign mem_busy_o       = (state != MEM_IDLE);

    // Next-state, counter and access-strobe decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        direct     = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (dcache2mem_req_i) begin
                    accept   = 1'b1;
                    cnt_next = load_val;
                    if (load_val == 4'd0) begin
                        access     = 1'b1;
                        direct     = 1'b1;
                        state_next = MEM_ACK;
                    end else begin
                        state_next = MEM_BUSY;
                    end
                end
            end
            MEM_BUSY: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    cnt_next   = 4'd0;
                    access     = 1'b1;
                    state_next = MEM_ACK;
                end
            end
            MEM_ACK: begin
                state_next = MEM_IDLE;
            end
            default: begin
                state_next = MEM_IDLE;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture every request field at accept so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            cap_wr   <= dcache2mem_wr_i;
            cap_idx  <= req_idx;
            cap_data <= dcache2mem_data_i;
        end
    end

    mem_line_ram #(
        .LINES (MEM_LINES),
        .WIDTH (LINE_WIDTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (acc_idx),
        .wdata (acc_data),
        .rdata (mem2dcache_data_o)
    );

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder: one default-latency instance and
// one with a single-cycle read latency.
module tb_dcache_mem_responder;

    localparam logic [127:0] LINE_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] LINE_1 = 128'h11111111_11111111_11111111_11111111;
    localparam logic [127:0] LINE_2 = 128'h22222222_22222222_22222222_22222222;
    localparam logic [127:0] LINE_3 = 128'h33333333_33333333_33333333_33333333;
    localparam logic [127:0] LINE_4 = 128'h44444444_44444444_44444444_44444444;
    localparam logic [127:0] LINE_5 = 128'h55555555_55555555_55555555_55555555;
    localparam logic [127:0] LINE_7 = 128'h77777777_77777777_77777777_77777777;
    localparam logic [127:0] LINE_9 = 128'h99999999_99999999_99999999_99999999;
    localparam logic [127:0] LINE_B = 128'hABCDEF01_23456789_0F1E2D3C_4B5A6978;

    logic         clk;
    logic         rst;

    logic         req0, wr0, ack0, busy0;
    logic [31:0]  addr0;
    logic [127:0] wdata0, rdata0;

    logic         req1, wr1, ack1, busy1;
    logic [31:0]  addr1;
    logic [127:0] wdata1, rdata1;

    int vectors    = 0;
    int miscompares = 0;

    dcache_mem_responder dut0 (
        .clk               (clk),
        .rst               (rst),
        .dcache2mem_req_i  (req0),
        .dcache2mem_wr_i   (wr0),
        .dcache2mem_addr_i (addr0),
        .dcache2mem_data_i (wdata0),
        .mem2dcache_data_o (rdata0),
        .mem2dcache_ack_o  (ack0),
        .mem_busy_o        (busy0)
    );

    dcache_mem_responder #(.RD_LATENCY(1)) dut1 (
        .clk               (clk),
        .rst               (rst),
        .dcache2mem_req_i  (req1),
        .dcache2mem_wr_i   (wr1),
        .dcache2mem_addr_i (addr1),
        .dcache2mem_data_i (wdata1),
        .mem2dcache_data_o (rdata1),
        .mem2dcache_ack_o  (ack1),
        .mem_busy_o        (busy1)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [127:0] data);
        req0   = 1'b1;
        wr0    = wr;
        addr0  = addr;
        wdata0 = data;
    endtask

    // One full handshake on dut0 with latency, busy, data and ack-width checks.
    task automatic runTxn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [127:0] data, input logic [127:0] exp_data,
                          input int exp_lat);
        int           ack_at;
        int           busy_cnt;
        logic [127:0] got;
        ack_at   = 0;
        busy_cnt = 0;
        got      = 'x;
        applyStimulus(wr, addr, data);
        for (int c = 1; c <= 32 && ack_at == 0; c++) begin
            tick();
            if (busy0) busy_cnt++;
            if (ack0) begin
                ack_at = c;
                got    = rdata0;
                req0   = 1'b0;
            end
        end
        req0 = 1'b0;
        checkOutput({tag, "_lat"}, 128'(ack_at), 128'(exp_lat));
        checkOutput({tag, "_busy"}, 128'(busy_cnt), 128'(exp_lat));
        checkOutput({tag, "_data"}, got, exp_data);
        tick();
        checkOutput({tag, "_ackw"}, 128'(ack0), 128'(0));
        checkOutput({tag, "_idle"}, 128'(busy0), 128'(0));
    endtask

    // Directed sequence.
    initial begin
        int           ack_at;
        int           acks;
        logic [127:0] got;
        logic [3:0]   pat;

        rst = 1'b1;
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        tick();
        tick();
        checkOutput("rst_ack0", 128'(ack0), 128'(0));
        checkOutput("rst_busy0", 128'(busy0), 128'(0));
        checkOutput("rst_data0", rdata0, 128'(0));
        checkOutput("rst_ack1", 128'(ack1), 128'(0));
        checkOutput("rst_busy1", 128'(busy1), 128'(0));
        rst = 1'b0;

        // Preload line 4, read it back, then write/read line 8.
        runTxn("wr_40", 1'b1, 32'h0000_0040, LINE_A, 128'(0), 4);
        runTxn("rd_40", 1'b0, 32'h0000_0040, '0, LINE_A, 4);
        runTxn("wr_80", 1'b1, 32'h0000_0080, LINE_1, LINE_A, 4);
        runTxn("rd_80", 1'b0, 32'h0000_0080, '0, LINE_1, 4);
        runTxn("wr_100", 1'b1, 32'h0000_0100, LINE_5, LINE_1, 4);

        // Inputs changed while BUSY must not affect the captured write.
        applyStimulus(1'b1, 32'h0000_00C0, LINE_7);
        tick();
        wr0 = 1'b0; addr0 = 32'h0000_0100; wdata0 = LINE_9;
        ack_at = 0;
        got    = 'x;
        for (int c = 2; c <= 32 && ack_at == 0; c++) begin
            tick();
            if (ack0) begin
                ack_at = c;
                got    = rdata0;
                req0   = 1'b0;
            end
        end
        req0 = 1'b0;
        checkOutput("chg_lat", 128'(ack_at), 128'(4));
        checkOutput("chg_data", got, LINE_1);
        tick();
        runTxn("chg_rd_c0", 1'b0, 32'h0000_00C0, '0, LINE_7, 4);
        runTxn("chg_rd_100", 1'b0, 32'h0000_0100, '0, LINE_5, 4);

        // Upper address bits alias onto line 1.
        runTxn("wr_4010", 1'b1, 32'h0000_4010, LINE_2, LINE_5, 4);
        runTxn("rd_10", 1'b0, 32'h0000_0010, '0, LINE_2, 4);

        // Reset two cycles into a write drops it.
        applyStimulus(1'b1, 32'h0000_0080, LINE_3);
        tick();
        tick();
        rst = 1'b1; req0 = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("rstA_busy", 128'(busy0), 128'(0));
        checkOutput("rstA_ack", 128'(ack0), 128'(0));
        checkOutput("rstA_data", rdata0, 128'(0));
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack0) acks++;
        end
        checkOutput("rstA_noack", 128'(acks), 128'(0));

        // Reset on the commit edge still drops the write.
        applyStimulus(1'b1, 32'h0000_0010, LINE_4);
        tick();
        tick();
        tick();
        rst = 1'b1; req0 = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("rstB_busy", 128'(busy0), 128'(0));
        checkOutput("rstB_ack", 128'(ack0), 128'(0));
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack0) acks++;
        end
        checkOutput("rstB_noack", 128'(acks), 128'(0));

        // A request held during reset is accepted only after reset releases.
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0000_0080, '0);
        tick();
        checkOutput("rst_req_busy", 128'(busy0), 128'(0));
        rst = 1'b0;
        runTxn("rd_80_old", 1'b0, 32'h0000_0080, '0, LINE_1, 4);
        runTxn("rd_10_old", 1'b0, 32'h0000_0010, '0, LINE_2, 4);

        // Single-cycle read latency instance: write, then back-to-back reads.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0040; wdata1 = LINE_B;
        ack_at = 0;
        for (int c = 1; c <= 32 && ack_at == 0; c++) begin
            tick();
            if (ack1) begin
                ack_at = c;
                req1   = 1'b0;
            end
        end
        req1 = 1'b0;
        checkOutput("l1_wr_lat", 128'(ack_at), 128'(4));
        tick();
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0040; wdata1 = '0;
        pat = '0;
        got = 'x;
        for (int c = 1; c <= 4; c++) begin
            tick();
            pat[c-1] = ack1;
            if (c == 1) got = rdata1;
        end
        req1 = 1'b0;
        checkOutput("l1_b2b_acks", 128'(pat), 128'(4'b0101));
        checkOutput("l1_rd_data", got, LINE_B);
        tick();
        checkOutput("l1_idle", 128'(busy1), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
